// File: rtl/hex_cmd_parser.sv
// hex_cmd_parser: parses ASCII "<hexA>(+|-)<hexB>(=|CR)" byte streams into an
// add/sub command for a 32-bit adder stage, with ready/valid hand-off.
// Optional build macro: LOWERCASE_HEX_EN (accept 'a'-'f' as hex digits).
module hex_cmd_parser #(
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_sub,
  output logic        c_in,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  typedef enum logic [1:0] {IDLE, OPA, OPB, ISSUE} state_t;

  state_t           r_state;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_op_sub;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_valid;
  logic             r_err;
  logic             r_rx_ready;

  logic       w_is_digit;
  logic [3:0] w_nibble;
  logic       w_consume;
  logic       w_is_op;
  logic       w_is_term;
  logic       w_cnt_full;
  logic       w_go_idle;
  logic       w_raise_err;

  // Hex digit decode of the incoming byte
  always_comb begin
    w_is_digit = 1'b0;
    w_nibble   = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0] + 4'd9;
    end
`ifdef LOWERCASE_HEX_EN
    else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      w_is_digit = 1'b1;
      w_nibble   = rx_data[3:0] + 4'd9;
    end
`endif
  end

  assign w_consume  = rx_valid && (r_state != ISSUE) && (rx_data != CH_SPACE);
  assign w_is_op    = (rx_data == CH_PLUS) || (rx_data == CH_MINUS);
  assign w_is_term  = (rx_data == CH_EQ) || (rx_data == CH_CR);
  assign w_cnt_full = (r_cnt == CNT_W'(MAX_DIGITS));

  // Classify the current cycle: abort/complete back to IDLE and/or flag an error
  always_comb begin
    w_go_idle   = 1'b0;
    w_raise_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_consume && !w_is_digit) w_raise_err = 1'b1;
      end
      OPA, OPB: begin
        if (w_consume) begin
          if (w_is_digit) begin
            if (w_cnt_full) begin
              w_go_idle   = 1'b1;
              w_raise_err = 1'b1;
            end
          end else if (rx_data == CH_ESC) begin
            w_go_idle = 1'b1;
          end else if (r_state == OPA && w_is_op) begin
            w_go_idle = 1'b0;
          end else if (r_state == OPB && w_is_term) begin
            if (r_cnt == '0) begin
              w_go_idle   = 1'b1;
              w_raise_err = 1'b1;
            end
          end else begin
            w_go_idle   = 1'b1;
            w_raise_err = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) w_go_idle = 1'b1;
      end
      default: w_go_idle = 1'b1;
    endcase
  end

  // Parser FSM with registered operands and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_sub    <= 1'b0;
      r_cnt       <= '0;
      r_cmd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rx_ready  <= 1'b1;
    end else begin
      r_err <= w_raise_err;
      if (w_go_idle) begin
        r_state     <= IDLE;
        r_op_a      <= '0;
        r_op_b      <= '0;
        r_op_sub    <= 1'b0;
        r_cnt       <= '0;
        r_cmd_valid <= 1'b0;
        r_rx_ready  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_consume && w_is_digit) begin
              r_op_a  <= 32'(w_nibble);
              r_cnt   <= CNT_W'(1);
              r_state <= OPA;
            end
          end
          OPA: begin
            if (w_consume) begin
              if (w_is_digit) begin
                r_op_a <= {r_op_a[27:0], w_nibble};
                r_cnt  <= r_cnt + CNT_W'(1);
              end else if (w_is_op) begin
                r_op_sub <= (rx_data == CH_MINUS);
                r_op_b   <= '0;
                r_cnt    <= '0;
                r_state  <= OPB;
              end
            end
          end
          OPB: begin
            if (w_consume) begin
              if (w_is_digit) begin
                r_op_b <= {r_op_b[27:0], w_nibble};
                r_cnt  <= r_cnt + CNT_W'(1);
              end else if (w_is_term) begin
                r_state     <= ISSUE;
                r_cmd_valid <= 1'b1;
                r_rx_ready  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign rx_ready  = r_rx_ready;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_sub    = r_op_sub;
  assign c_in      = r_op_sub;
  assign cmd_valid = r_cmd_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_hex_cmd_parser.sv
// Self-checking bench for hex_cmd_parser: directed command strings followed by
// randomized byte traffic, compared every cycle against a string-level parser model.
module tb_hex_cmd_parser;

  localparam int MAXD = 8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic        c_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        err;

  hex_cmd_parser #(.MAX_DIGITS(MAXD)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .c_in      (c_in),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0=idle, 1=collecting A, 2=collecting B, 3=command pending
  int     m_phase;
  int     m_cnt;
  longint m_a;
  longint m_b;
  bit     m_sub;
  bit     m_err;

  int          n_cmd;
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic        last_sub;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
`ifdef LOWERCASE_HEX_EN
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
`endif
    return -1;
  endfunction

  task automatic model_clear();
    m_phase = 0;
    m_cnt   = 0;
    m_a     = 0;
    m_b     = 0;
    m_sub   = 1'b0;
  endtask

  // Apply the inputs present at a rising edge to the model
  task automatic model_step();
    int d;
    m_err = 1'b0;
    if (!rst_n) begin
      model_clear();
    end else if (m_phase == 3) begin
      if (cmd_ready) model_clear();
    end else if (rx_valid && rx_data != 8'h20) begin
      d = hexval(rx_data);
      if (m_phase == 0) begin
        if (d >= 0) begin
          m_a = d; m_cnt = 1; m_phase = 1;
        end else begin
          m_err = 1'b1;
        end
      end else if (d >= 0) begin
        if (m_cnt == MAXD) begin
          m_err = 1'b1; model_clear();
        end else begin
          if (m_phase == 1) m_a = (m_a * 16 + d) & 64'hFFFF_FFFF;
          else              m_b = (m_b * 16 + d) & 64'hFFFF_FFFF;
          m_cnt++;
        end
      end else if (rx_data == 8'h1B) begin
        model_clear();
      end else if (m_phase == 1 && (rx_data == 8'h2B || rx_data == 8'h2D)) begin
        m_sub = (rx_data == 8'h2D); m_b = 0; m_cnt = 0; m_phase = 2;
      end else if (m_phase == 2 && (rx_data == 8'h3D || rx_data == 8'h0D)) begin
        if (m_cnt >= 1) m_phase = 3;
        else begin
          m_err = 1'b1; model_clear();
        end
      end else begin
        m_err = 1'b1; model_clear();
      end
    end
  endtask

  task automatic compare_all();
    check("rx_ready",  32'(rx_ready),  32'(m_phase != 3));
    check("cmd_valid", 32'(cmd_valid), 32'(m_phase == 3));
    check("err",       32'(err),       32'(m_err));
    check("op_a",      op_a,           32'(m_a));
    check("op_b",      op_b,           32'(m_b));
    check("op_sub",    32'(op_sub),    32'(m_sub));
    check("c_in",      32'(c_in),      32'(m_sub));
  endtask

  // One clock: record a handshake, advance model at the edge, compare mid-cycle
  task automatic tick();
    if (rst_n && cmd_valid && cmd_ready) begin
      n_cmd++;
      last_a   = op_a;
      last_b   = op_b;
      last_sub = op_sub;
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic logic [7:0] rand_byte();
    int k;
    int v;
    k = int'($urandom_range(0, 15));
    v = int'($urandom_range(0, 15));
    case (k)
      6:  return 8'h2B;
      7:  return 8'h2D;
      8:  return 8'h3D;
      9:  return 8'h0D;
      10: return 8'h20;
      11: return 8'h1B;
      12: return 8'(8'h61 + $urandom_range(0, 5));
      13: return 8'($urandom_range(0, 255));
      default: return (v < 10) ? 8'(48 + v) : 8'(55 + v);
    endcase
  endfunction

  int n0;

  initial begin
    rst_n     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b0;
    n_cmd     = 0;
    m_err     = 1'b0;
    model_clear();

    // Reset state
    tick();
    tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // "1A+2F=" with downstream always ready
    cmd_ready = 1'b1;
    n0 = n_cmd;
    send_str("1A+2F=");
    tick(); tick(); tick();
    check("add_ncmd", 32'(n_cmd - n0), 32'd1);
    check("add_op_a", last_a, 32'h1A);
    check("add_op_b", last_b, 32'h2F);
    check("add_sub", 32'(last_sub), 32'd0);

    // "FFFFFFFF-1\r" with back-pressure and a dropped byte while pending
    cmd_ready = 1'b0;
    n0 = n_cmd;
    send_str("FFFFFFFF-1");
    send_byte(8'h0D);
    tick(); tick();
    send_byte(8'h35);
    tick(); tick();
    check("sub_held", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    tick(); tick();
    check("sub_ncmd", 32'(n_cmd - n0), 32'd1);
    check("sub_op_a", last_a, 32'hFFFF_FFFF);
    check("sub_op_b", last_b, 32'h1);
    check("sub_sub", 32'(last_sub), 32'd1);

    // Digit overflow then a clean command
    n0 = n_cmd;
    send_str("12345678");
    send_byte(8'h39);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_op_a", op_a, 32'd0);
    send_str("1+1=");
    tick(); tick();
    check("ovf_ncmd", 32'(n_cmd - n0), 32'd1);
    check("ovf_op_a_next", last_a, 32'd1);
    check("ovf_op_b_next", last_b, 32'd1);

    // Malformed commands and ESC abort
    n0 = n_cmd;
    send_str("+5=");
    send_str("7+=");
    send_str("7+");
    send_byte(8'h1B);
    check("esc_no_err", 32'(err), 32'd0);
    tick(); tick();
    check("bad_ncmd", 32'(n_cmd - n0), 32'd0);

    // Lowercase digits
    n0 = n_cmd;
    send_str("ab+1=");
    tick(); tick();
`ifdef LOWERCASE_HEX_EN
    check("lc_ncmd", 32'(n_cmd - n0), 32'd1);
    check("lc_op_a", last_a, 32'hAB);
`else
    check("lc_ncmd", 32'(n_cmd - n0), 32'd0);
`endif

    // Reset mid-command discards it
    n0 = n_cmd;
    send_str("12+3");
    rst_n = 1'b0;
    tick(); tick();
    check("midrst_op_a", op_a, 32'd0);
    rst_n = 1'b1;
    send_byte(8'h3D);
    check("midrst_err", 32'(err), 32'd1);
    tick(); tick();
    check("midrst_ncmd", 32'(n_cmd - n0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      rx_valid  = ($urandom_range(0, 9) < 7);
      rx_data   = rand_byte();
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst_n    = 1'b1;
    rx_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_cmd_parser.md
HEX_CMD_PARSER -- requirements
Module: hex_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 8, meaning max hex digits per operand (legal 1..8).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rx_data  input  8  ASCII byte from UART receiver.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port rx_ready  output  1  high when a byte is accepted (all states except ISSUE).
REQ-007 SHALL have port op_a  output  32  operand A, zero-extended.
REQ-008 SHALL have port op_b  output  32  operand B, zero-extended.
REQ-009 SHALL have port op_sub  output  1  1 = subtract, 0 = add.
REQ-010 SHALL have port c_in  output  1  carry-in for the downstream adder/subtractor; equals op_sub.
REQ-011 SHALL have port cmd_valid  output  1  command held valid for the 32-bit add/sub stage.
REQ-012 SHALL have port cmd_ready  input  1  downstream accepts the command when high with cmd_valid.
REQ-013 SHALL have port err  output  1  one-cycle pulse on a malformed command.

Function
REQ-014 SHALL implement FSM states IDLE, OPA, OPB, ISSUE; bytes are consumed only when rx_valid is high and the state is not ISSUE.
REQ-015 SHALL decode hex digits '0'-'9' (0x30-0x39) and 'A'-'F' (0x41-0x46) to nibbles 0-15.
REQ-016 SHALL ignore space (0x20) in every consuming state, with no state change.
REQ-017 IDLE: on a digit, SHALL load op_a <= nibble, set digit count to 1 and go to OPA; a non-digit, non-space byte SHALL pulse err and stay in IDLE.
REQ-018 OPA: on a digit, SHALL shift op_a <= {op_a[27:0], nibble} and increment the count.
REQ-019 OPA: '+' (0x2B) SHALL set op_sub=0, '-' (0x2D) SHALL set op_sub=1; both SHALL clear op_b and the count and go to OPB.
REQ-020 OPB: on a digit, SHALL shift into op_b as in REQ-018.
REQ-021 OPB: '=' (0x3D) or CR (0x0D) with count >= 1 SHALL go to ISSUE, with cmd_valid high on the following cycle.
REQ-022 ISSUE: cmd_valid, op_a, op_b, op_sub and c_in SHALL hold stable until the cycle in which cmd_ready is high; the FSM SHALL then go to IDLE and drop cmd_valid on the next cycle.
REQ-023 ISSUE: rx bytes SHALL be dropped, because rx_ready=0.
REQ-024 A digit arriving when count == MAX_DIGITS SHALL pulse err and return to IDLE.
REQ-025 A terminator in OPB with count 0 SHALL pulse err and return to IDLE.
REQ-026 Any other unexpected byte in OPA or OPB SHALL pulse err and return to IDLE.
REQ-027 ESC (0x1B) in OPA or OPB SHALL abort to IDLE without err.
REQ-028 On every return to IDLE, op_a, op_b, op_sub and the count SHALL be cleared.
REQ-029 cmd_valid and err SHALL be registered outputs; err SHALL be high for exactly one cycle per error.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE, with op_a=0, op_b=0, op_sub=0, c_in=0, cmd_valid=0, err=0, rx_ready=1 and count=0.
REQ-031 Reset asserted mid-command, including in ISSUE, SHALL discard the command immediately; no cmd_valid SHALL follow deassertion.

Configuration
REQ-032 When LOWERCASE_HEX_EN is defined, 'a'-'f' (0x61-0x66) SHALL decode as 10-15 in every digit position.
REQ-033 When LOWERCASE_HEX_EN is undefined, 'a'-'f' SHALL be treated as unexpected bytes per REQ-017/REQ-026.

Verification
REQ-034 Bytes "1A+2F=" with cmd_ready=1 -> one cmd_valid cycle, op_a=0x1A, op_b=0x2F, op_sub=0, c_in=0.
REQ-035 Bytes "FFFFFFFF-1\r" -> op_a=0xFFFFFFFF, op_b=0x1, op_sub=1, c_in=1; cmd_valid held while cmd_ready=0 for 5 cycles; a byte sent meanwhile is ignored and outputs stay stable.
REQ-036 Bytes "123456789" (MAX_DIGITS=8) -> err pulse on the 9th byte, state IDLE, op_a=0; next "1+1=" -> op_a=1, op_b=1.
REQ-037 Bytes "+5=" -> err on '+'; "7+=" -> err on '='; "7+" then ESC -> no err, IDLE; no cmd_valid in any case.
REQ-038 Bytes "ab+1=" -> with LOWERCASE_HEX_EN op_a=0xAB; without it, err on 'a' and no cmd_valid.
REQ-039 Bytes "12+3" then rst_n low for 2 cycles then high -> all outputs 0; then "=" -> err, no cmd_valid.
